// File: rtl/sfq_pkg.sv
// Shared definitions for the SFQ pulse collector: control states,
// default configuration and the pulse counter saturation value.
package sfq_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_TS_W        = 16;

  localparam logic [15:0] PULSE_CNT_MAX = 16'hFFFF;

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } sfq_state_e;

endpackage

// File: rtl/sfq_evt_fifo.sv
// Event FIFO for the SFQ pulse collector.
// Configuration macro SFQ_TSTAMP_EN: when defined, the FIFO stores one
// WIDTH-bit timestamp per entry; when undefined, only the occupancy
// counter is kept and there are no data ports.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sfq_evt_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
`ifdef SFQ_TSTAMP_EN
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
`endif
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Occupancy bookkeeping: a simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

`ifdef SFQ_TSTAMP_EN
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign rd_data = mem_q[rd_ptr_q];

  // Pointer advance and storage write; pointers wrap since DEPTH is 2^n
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  // Storage and pointer registers; cleared so the head reads zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
`endif

endmodule

// File: rtl/sfq_pulse_collector.sv
// SFQ pulse collector: synchronizes a toggle-encoded SFQ line, detects
// each level change as one pulse, counts pulses and queues events.
// Configuration macro SFQ_TSTAMP_EN: when defined, a free-running
// timestamp counter is kept and each event carries the timestamp of the
// cycle it was detected in (ev_ts port); when undefined, both are removed.
module sfq_pulse_collector
  import sfq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int TS_W        = DEF_TS_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sfq_in,
  output logic            ev_valid,
  input  logic            ev_ready,
`ifdef SFQ_TSTAMP_EN
  output logic [TS_W-1:0] ev_ts,
`endif
  output logic [15:0]     pulse_cnt,
  output logic            err_ovf,
  output logic            err_x,
  input  logic            clr_err
);

  // WARM spans cycles 0..SYNC_STAGES after release so prev sees a settled line
  localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES);

  sfq_state_e             state_q, state_d;
  logic [2:0]             warm_cnt_q, warm_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   det_q, det_d;
  logic [15:0]            pulse_cnt_q, pulse_cnt_d;
  logic                   err_ovf_q, err_ovf_d;
  logic                   err_x_q, err_x_d;
  logic                   sync_out;
  logic                   x_seen;
  logic                   toggle;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic                   drop;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign fifo_pop  = ev_ready & ~fifo_empty;
  assign drop      = det_q & fifo_full & ~fifo_pop;
  assign ev_valid  = ~fifo_empty;
  assign pulse_cnt = pulse_cnt_q;
  assign err_ovf   = err_ovf_q;
  assign err_x     = err_x_q;

  // Control FSM: hold in WARM for a fixed number of cycles, then RUN
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    case (state_q)
      ST_WARM: begin
        if (warm_cnt_q == WARM_LAST) state_d    = ST_RUN;
        else                         warm_cnt_d = warm_cnt_q + 3'd1;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_WARM;
    endcase
  end

  // Synchronizer shift, prev tracking and toggle detection
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sfq_in};
    x_seen = 1'b0;
`ifndef SYNTHESIS
    x_seen = $isunknown(sync_out);
`endif
    prev_d = prev_q;
    toggle = 1'b0;
    if (!x_seen) begin
      prev_d = sync_out;
      toggle = (state_q == ST_RUN) && (sync_out != prev_q);
    end
  end

  // Pulse counting, event staging and sticky error flags
  always_comb begin
    det_d       = toggle;
    pulse_cnt_d = pulse_cnt_q;
    if (toggle && (pulse_cnt_q != PULSE_CNT_MAX)) pulse_cnt_d = pulse_cnt_q + 16'd1;
    err_ovf_d = drop   | (err_ovf_q & ~clr_err);
    err_x_d   = x_seen | (err_x_q   & ~clr_err);
  end

  // Control, synchronizer and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WARM;
      warm_cnt_q  <= '0;
      sync_q      <= '0;
      prev_q      <= 1'b0;
      det_q       <= 1'b0;
      pulse_cnt_q <= '0;
      err_ovf_q   <= 1'b0;
      err_x_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      det_q       <= det_d;
      pulse_cnt_q <= pulse_cnt_d;
      err_ovf_q   <= err_ovf_d;
      err_x_q     <= err_x_d;
    end
  end

`ifdef SFQ_TSTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] det_ts_q, det_ts_d;

  // Free-running timestamp; the detection-cycle value travels with the event
  always_comb begin
    ts_d     = ts_q + TS_W'(1);
    det_ts_d = ts_q;
  end

  // Timestamp registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q     <= '0;
      det_ts_q <= '0;
    end else begin
      ts_q     <= ts_d;
      det_ts_q <= det_ts_d;
    end
  end
`endif

  sfq_evt_fifo #(
    .WIDTH (TS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (det_q),
    .pop     (fifo_pop),
`ifdef SFQ_TSTAMP_EN
    .wr_data (det_ts_q),
    .rd_data (ev_ts),
`endif
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_sfq_pulse_collector.sv
// Testbench for sfq_pulse_collector. Timestamp checks are compiled in
// only when SFQ_TSTAMP_EN is defined, matching the design's ev_ts port.
module tb_sfq_pulse_collector;

  localparam int S     = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sfq_in;
  logic        ev_ready;
  logic        clr_err;
  logic        ev_valid;
  logic [15:0] pulse_cnt;
  logic        err_ovf;
  logic        err_x;
`ifdef SFQ_TSTAMP_EN
  logic [15:0] ev_ts;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit four_state;

  // Reference model: queued event timestamps, pending detections and pushes
  int          mq[$];
  int          det_pend[$];
  int          push_pend[$];
  int          x_pend[$];
  logic        m_level;
  logic [15:0] m_cnt;
  logic        m_ovf;
  logic        m_x;

  always #5 clk = ~clk;

  sfq_pulse_collector #(
    .SYNC_STAGES (S),
    .FIFO_DEPTH  (DEPTH),
    .TS_W        (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sfq_in    (sfq_in),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
`ifdef SFQ_TSTAMP_EN
    .ev_ts     (ev_ts),
`endif
    .pulse_cnt (pulse_cnt),
    .err_ovf   (err_ovf),
    .err_x     (err_x),
    .clr_err   (clr_err)
  );

  // Reset the DUT and the model; returns at the release negedge with cyc = 0
  task automatic do_reset(input logic lvl);
    @(negedge clk);
    rst_n = 1'b0; sfq_in = lvl; ev_ready = 1'b0; clr_err = 1'b0;
    mq.delete(); det_pend.delete(); push_pend.delete(); x_pend.delete();
    m_level = 1'b0; m_cnt = '0; m_ovf = 1'b0; m_x = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, step to next negedge
  task automatic drive_cycle(input logic s, input bit rdy, input bit clr);
    bit pop, pushing, drop, xs;
    int d, dummy;
    sfq_in = s; ev_ready = rdy; clr_err = clr;
    pop     = rdy && (mq.size() > 0);
    pushing = (push_pend.size() > 0) && (push_pend[0] + 1 == cyc);
    drop    = 1'b0;
    d       = 0;
    if (pushing) begin
      d = push_pend.pop_front();
      if (mq.size() == DEPTH && !pop) drop = 1'b1;
    end
    if (pop) dummy = mq.pop_front();
    if (pushing && !drop) mq.push_back(d);
    if (det_pend.size() > 0 && det_pend[0] == cyc) begin
      dummy = det_pend.pop_front();
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      push_pend.push_back(cyc);
    end
    m_ovf = drop | (m_ovf & !clr);
    xs = (x_pend.size() > 0) && (x_pend[0] == cyc);
    if (xs) dummy = x_pend.pop_front();
    m_x = xs | (m_x & !clr);
    if ($isunknown(s)) begin
      x_pend.push_back(cyc + S);
    end else if (s !== m_level) begin
      m_level = s;
      if (cyc >= 1) det_pend.push_back(cyc + S);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sfq_in = 1'b1; ev_ready = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (ev_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b want 0", ev_valid); end
    n_vec++; if (pulse_cnt !== 16'd0) begin n_bad++; $display("[TB] FAIL reset_cnt: got %0h want 0", pulse_cnt); end
    n_vec++; if (err_ovf !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ovf: got %b want 0", err_ovf); end
    n_vec++; if (err_x !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_errx: got %b want 0", err_x); end
`ifdef SFQ_TSTAMP_EN
    n_vec++; if (ev_ts !== 16'd0) begin n_bad++; $display("[TB] FAIL reset_ts: got %0h want 0", ev_ts); end
`endif
    do_reset(1'b1);
    repeat (20) begin
      drive_cycle(1'b1, 1'b0, 1'b0);
      n_vec++; if (ev_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL hi_release_valid: cyc %0d got %b want 0", cyc, ev_valid); end
      n_vec++; if (pulse_cnt !== 16'd0) begin n_bad++; $display("[TB] FAIL hi_release_cnt: cyc %0d got %0d want 0", cyc, pulse_cnt); end
    end
  endtask

  task automatic test_single_event();
    do_reset(1'b0);
    while (cyc < 10) drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0);
    while (cyc < 16) begin
      n_vec++; if (ev_valid !== (cyc == 14)) begin n_bad++; $display("[TB] FAIL single_valid: cyc %0d got %b want %b", cyc, ev_valid, cyc == 14); end
`ifdef SFQ_TSTAMP_EN
      if (cyc == 14) begin
        n_vec++; if (ev_ts !== 16'd12) begin n_bad++; $display("[TB] FAIL single_ts: got %0d want 12", ev_ts); end
      end
`endif
      drive_cycle(1'b1, 1'b1, 1'b0);
    end
    n_vec++; if (pulse_cnt !== 16'd1) begin n_bad++; $display("[TB] FAIL single_cnt: got %0d want 1", pulse_cnt); end
  endtask

  task automatic test_overflow();
    logic lvl = 1'b0;
    int exp_ts[4] = '{7, 10, 13, 16};
    do_reset(1'b0);
    while (cyc < 30) begin
      if (cyc inside {5, 8, 11, 14, 17, 20}) lvl = ~lvl;
      drive_cycle(lvl, 1'b0, 1'b0);
    end
    n_vec++; if (err_ovf !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_flag: got %b want 1", err_ovf); end
    n_vec++; if (pulse_cnt !== 16'd6) begin n_bad++; $display("[TB] FAIL ovf_cnt: got %0d want 6", pulse_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (ev_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_drain_valid: entry %0d got %b want 1", i, ev_valid); end
`ifdef SFQ_TSTAMP_EN
      n_vec++; if (ev_ts !== 16'(exp_ts[i])) begin n_bad++; $display("[TB] FAIL ovf_drain_ts: entry %0d got %0d want %0d", i, ev_ts, exp_ts[i]); end
`endif
      drive_cycle(lvl, 1'b1, 1'b0);
    end
    n_vec++; if (ev_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_drained: got %b want 0", ev_valid); end
  endtask

  task automatic test_full_pop();
    logic lvl = 1'b0;
    int popped = 0;
    do_reset(1'b0);
    while (cyc < 25) begin
      if (cyc inside {2, 4, 6, 8, 14}) lvl = ~lvl;
      drive_cycle(lvl, cyc == 17, 1'b0);
    end
    n_vec++; if (err_ovf !== 1'b0) begin n_bad++; $display("[TB] FAIL fullpop_ovf: got %b want 0", err_ovf); end
    n_vec++; if (pulse_cnt !== 16'd5) begin n_bad++; $display("[TB] FAIL fullpop_cnt: got %0d want 5", pulse_cnt); end
`ifdef SFQ_TSTAMP_EN
    n_vec++; if (ev_ts !== 16'd6) begin n_bad++; $display("[TB] FAIL fullpop_head: got %0d want 6", ev_ts); end
`endif
    for (int i = 0; i < 8; i++) begin
      if (ev_valid === 1'b1) begin
        popped++;
`ifdef SFQ_TSTAMP_EN
        n_vec++; if (ev_ts !== 16'((mq.size() > 0) ? mq[0] : 0)) begin n_bad++; $display("[TB] FAIL fullpop_ts: pop %0d got %0d want %0d", popped, ev_ts, (mq.size() > 0) ? mq[0] : 0); end
`endif
      end
      drive_cycle(lvl, 1'b1, 1'b0);
    end
    n_vec++; if (popped !== 4) begin n_bad++; $display("[TB] FAIL fullpop_occupancy: got %0d want 4", popped); end
  endtask

  task automatic test_reset_mid();
    logic lvl = 1'b0;
    do_reset(1'b0);
    while (cyc < 12) begin
      if (cyc inside {2, 4, 6}) lvl = ~lvl;
      drive_cycle(lvl, 1'b0, 1'b0);
    end
    n_vec++; if (ev_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL mid_queued: got %b want 1", ev_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (ev_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_async_valid: got %b want 0", ev_valid); end
    n_vec++; if (pulse_cnt !== 16'd0) begin n_bad++; $display("[TB] FAIL mid_async_cnt: got %0d want 0", pulse_cnt); end
    n_vec++; if ({err_ovf, err_x} !== 2'b00) begin n_bad++; $display("[TB] FAIL mid_async_flags: got %b want 00", {err_ovf, err_x}); end
    do_reset(lvl);
    while (cyc < 10) begin
      drive_cycle((cyc >= 3) ? ~lvl : lvl, 1'b1, 1'b0);
      n_vec++; if (ev_valid !== (cyc == 7)) begin n_bad++; $display("[TB] FAIL mid_fresh_valid: cyc %0d got %b want %b", cyc, ev_valid, cyc == 7); end
`ifdef SFQ_TSTAMP_EN
      if (cyc == 7) begin
        n_vec++; if (ev_ts !== 16'd5) begin n_bad++; $display("[TB] FAIL mid_fresh_ts: got %0d want 5", ev_ts); end
      end
`endif
    end
  endtask

  task automatic test_clr_err();
    logic lvl = 1'b0;
    do_reset(1'b0);
    while (cyc < 10) begin
      if (cyc inside {1, 2, 3, 4, 5}) lvl = ~lvl;
      drive_cycle(lvl, 1'b0, 1'b0);
    end
    n_vec++; if (err_ovf !== 1'b1) begin n_bad++; $display("[TB] FAIL clr_ovf_set: got %b want 1", err_ovf); end
    drive_cycle(lvl, 1'b0, 1'b1);
    n_vec++; if (err_ovf !== 1'b0) begin n_bad++; $display("[TB] FAIL clr_ovf_cleared: got %b want 0", err_ovf); end
    lvl = ~lvl;
    while (cyc < 14) drive_cycle(lvl, 1'b0, 1'b0);
    drive_cycle(lvl, 1'b0, 1'b1);
    n_vec++; if (err_ovf !== 1'b1) begin n_bad++; $display("[TB] FAIL clr_vs_drop: got %b want 1", err_ovf); end
    drive_cycle(lvl, 1'b0, 1'b1);
    n_vec++; if (err_ovf !== 1'b0) begin n_bad++; $display("[TB] FAIL clr_after_drop: got %b want 0", err_ovf); end
    if (four_state) begin
      drive_cycle(1'bx, 1'b0, 1'b0);
      while (cyc < 20) drive_cycle(lvl, 1'b0, 1'b0);
      n_vec++; if (err_x !== 1'b1) begin n_bad++; $display("[TB] FAIL x_set: got %b want 1", err_x); end
      drive_cycle(1'bx, 1'b0, 1'b0);
      drive_cycle(lvl, 1'b0, 1'b0);
      drive_cycle(lvl, 1'b0, 1'b1);
      n_vec++; if (err_x !== 1'b1) begin n_bad++; $display("[TB] FAIL x_vs_clr: got %b want 1", err_x); end
      drive_cycle(lvl, 1'b0, 1'b0);
      drive_cycle(lvl, 1'b0, 1'b1);
      n_vec++; if (err_x !== 1'b0) begin n_bad++; $display("[TB] FAIL x_cleared: got %b want 0", err_x); end
    end
    n_vec++; if (pulse_cnt !== 16'd6) begin n_bad++; $display("[TB] FAIL clr_cnt: got %0d want 6", pulse_cnt); end
  endtask

  task automatic test_random();
    logic lvl = 1'b0;
    bit rdy, clr;
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) lvl = ~lvl;
      rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      drive_cycle(lvl, rdy, clr);
      n_vec++; if (ev_valid !== (mq.size() > 0)) begin n_bad++; $display("[TB] FAIL rnd_valid: cyc %0d got %b want %b", cyc, ev_valid, mq.size() > 0); end
      n_vec++; if (pulse_cnt !== m_cnt) begin n_bad++; $display("[TB] FAIL rnd_cnt: cyc %0d got %0d want %0d", cyc, pulse_cnt, m_cnt); end
      n_vec++; if (err_ovf !== m_ovf) begin n_bad++; $display("[TB] FAIL rnd_ovf: cyc %0d got %b want %b", cyc, err_ovf, m_ovf); end
      n_vec++; if (err_x !== m_x) begin n_bad++; $display("[TB] FAIL rnd_errx: cyc %0d got %b want %b", cyc, err_x, m_x); end
`ifdef SFQ_TSTAMP_EN
      if (mq.size() > 0) begin
        n_vec++; if (ev_ts !== 16'(mq[0])) begin n_bad++; $display("[TB] FAIL rnd_ts: cyc %0d got %0d want %0d", cyc, ev_ts, mq[0]); end
      end
`endif
    end
  endtask

  initial begin
    logic probe;
    probe = 1'bx;
    four_state = $isunknown(probe);
    test_reset();
    test_single_event();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_clr_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
